trap_ctrl: RTL and testbench

- Multi-lane successor to the single-lane commit exception controller.
- Sits between the ROB commit ports and the CSR file / pipeline flush network.
- Scans CMT_WIDTH commit lanes in program order and selects the oldest trap, xRET or WFI event.
- Produces registered trap, return and redirect pulses; counts retired instructions; holds commit in a parked state during flush drain and WFI sleep.

---
 rtl/trap_ctrl_if.sv | 48 ++++
 rtl/trap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Commit-side bundle between the ROB commit ports, the trap controller and the CSR/flush network.
// Lane 0 is the oldest. A lane commits when rob_cmt_valid_i[i] is high and cmt_stall_o is low.
// While cmt_stall_o is high the controller ignores every lane and the ROB must hold its entries.
interface trap_ctrl_if #(
    parameter int CMT_WIDTH             = 2,
    parameter int PC_WIDTH              = 40,
    parameter int EXCEPTION_CAUSE_WIDTH = 4,
    parameter int RET_W                 = $clog2(CMT_WIDTH + 1)
);
    logic [CMT_WIDTH-1:0]                       rob_cmt_valid_i;
    logic [CMT_WIDTH*PC_WIDTH-1:0]              rob_cmt_pc_i;
    logic [CMT_WIDTH-1:0]                       rob_cmt_exp_i;
    logic [CMT_WIDTH*EXCEPTION_CAUSE_WIDTH-1:0] rob_cmt_ecause_i;
    logic [CMT_WIDTH-1:0]                       rob_cmt_mret_i;
    logic [CMT_WIDTH-1:0]                       rob_cmt_sret_i;
    logic [CMT_WIDTH-1:0]                       rob_cmt_wfi_i;
    logic                                       predict_miss_i;
    logic                                       interrupt_i;

    logic                             cmt_stall_o;
    logic                             global_trap_o;
    logic                             global_mret_o;
    logic                             global_sret_o;
    logic                             global_ret_o;
    logic                             global_wfi_o;
    logic                             global_predict_miss_o;
    logic [PC_WIDTH-1:0]              csr_pc_o;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_o;
    logic                             csr_intr_o;
    logic [RET_W-1:0]                 csr_retired_o;
    logic [1:0]                       dbg_state;

    modport master (
        output rob_cmt_valid_i, rob_cmt_pc_i, rob_cmt_exp_i, rob_cmt_ecause_i,
               rob_cmt_mret_i, rob_cmt_sret_i, rob_cmt_wfi_i, predict_miss_i, interrupt_i,
        input  cmt_stall_o, global_trap_o, global_mret_o, global_sret_o, global_ret_o,
               global_wfi_o, global_predict_miss_o, csr_pc_o, csr_ecause_o, csr_intr_o,
               csr_retired_o, dbg_state
    );

    modport slave (
        input  rob_cmt_valid_i, rob_cmt_pc_i, rob_cmt_exp_i, rob_cmt_ecause_i,
               rob_cmt_mret_i, rob_cmt_sret_i, rob_cmt_wfi_i, predict_miss_i, interrupt_i,
        output cmt_stall_o, global_trap_o, global_mret_o, global_sret_o, global_ret_o,
               global_wfi_o, global_predict_miss_o, csr_pc_o, csr_ecause_o, csr_intr_o,
               csr_retired_o, dbg_state
    );
endinterface

// File: rtl/trap_ctrl.sv
// Multi-lane commit exception controller: picks the oldest trap/xRET/WFI among the commit lanes,
// emits registered trap/return/redirect pulses and parks commit during flush drain and WFI sleep.
module trap_ctrl #(
    parameter int CMT_WIDTH             = 2,
    parameter int PC_WIDTH              = 40,
    parameter int EXCEPTION_CAUSE_WIDTH = 4,
    parameter int FLUSH_CYCLES          = 2,
    parameter int RET_W                 = $clog2(CMT_WIDTH + 1)
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave cmt
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, WFI = 2'd2} state_t;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t                           state, state_n;
    logic [CNT_W-1:0]                 flush_cnt, flush_cnt_n;
    logic [PC_WIDTH-1:0]              saved_pc, saved_pc_n;
    logic                             trap_q, trap_n, mret_q, mret_n, sret_q, sret_n;
    logic                             pm_q, pm_n, intr_q, intr_n;
    logic [PC_WIDTH-1:0]              pc_q, pc_n;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] cause_q, cause_n;
    logic [RET_W-1:0]                 retired_q, retired_n;

    logic                             alive, ev_found, ev_exp, ev_mret, ev_sret;
    logic [PC_WIDTH-1:0]              ev_pc;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] ev_cause;
    logic [RET_W-1:0]                 ret_cnt;
    logic                             irq_take;

    // Walk lanes oldest-first; the first flagged lane stops retirement of everything younger.
    always_comb begin
        alive    = 1'b1;
        ev_found = 1'b0;
        ev_exp   = 1'b0;
        ev_mret  = 1'b0;
        ev_sret  = 1'b0;
        ev_pc    = '0;
        ev_cause = '0;
        ret_cnt  = '0;
        for (int i = 0; i < CMT_WIDTH; i++) begin
            if (alive && cmt.rob_cmt_valid_i[i]) begin
                if (cmt.rob_cmt_exp_i[i] | cmt.rob_cmt_mret_i[i] |
                    cmt.rob_cmt_sret_i[i] | cmt.rob_cmt_wfi_i[i]) begin
                    alive    = 1'b0;
                    ev_found = 1'b1;
                    ev_exp   = cmt.rob_cmt_exp_i[i];
                    ev_mret  = cmt.rob_cmt_mret_i[i];
                    ev_sret  = cmt.rob_cmt_sret_i[i];
                    ev_pc    = cmt.rob_cmt_pc_i[i*PC_WIDTH +: PC_WIDTH];
                    ev_cause = cmt.rob_cmt_ecause_i[i*EXCEPTION_CAUSE_WIDTH +: EXCEPTION_CAUSE_WIDTH];
                    if (!cmt.rob_cmt_exp_i[i]) ret_cnt = ret_cnt + RET_W'(1);
                end else begin
                    ret_cnt = ret_cnt + RET_W'(1);
                end
            end
        end
    end

    assign irq_take = cmt.interrupt_i && cmt.rob_cmt_valid_i[0];

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        saved_pc_n  = saved_pc;
        trap_n      = 1'b0;
        mret_n      = 1'b0;
        sret_n      = 1'b0;
        pm_n        = 1'b0;
        intr_n      = 1'b0;
        pc_n        = '0;
        cause_n     = '0;
        retired_n   = '0;
        case (state)
            IDLE: begin
                if (irq_take) begin
                    trap_n      = 1'b1;
                    intr_n      = 1'b1;
                    pc_n        = cmt.rob_cmt_pc_i[PC_WIDTH-1:0];
                    state_n     = FLUSH;
                    flush_cnt_n = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    retired_n = ret_cnt;
                    if (ev_found) begin
                        if (ev_exp) begin
                            trap_n  = 1'b1;
                            pc_n    = ev_pc;
                            cause_n = ev_cause;
                        end else if (ev_mret) begin
                            mret_n = 1'b1;
                        end else if (ev_sret) begin
                            sret_n = 1'b1;
                        end
                        if (ev_exp || ev_mret || ev_sret) begin
                            state_n     = FLUSH;
                            flush_cnt_n = CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            saved_pc_n = ev_pc + PC_WIDTH'(4);
                            state_n    = WFI;
                        end
                    end
                    // A trap/xRET flush supersedes the branch redirect.
                    pm_n = cmt.predict_miss_i && !(trap_n || mret_n || sret_n);
                end
            end
            WFI: begin
                if (cmt.interrupt_i) begin
                    trap_n      = 1'b1;
                    intr_n      = 1'b1;
                    pc_n        = saved_pc;
                    state_n     = FLUSH;
                    flush_cnt_n = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) state_n = IDLE;
                else flush_cnt_n = flush_cnt - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            saved_pc  <= '0;
            trap_q    <= 1'b0;
            mret_q    <= 1'b0;
            sret_q    <= 1'b0;
            pm_q      <= 1'b0;
            intr_q    <= 1'b0;
            pc_q      <= '0;
            cause_q   <= '0;
            retired_q <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            saved_pc  <= saved_pc_n;
            trap_q    <= trap_n;
            mret_q    <= mret_n;
            sret_q    <= sret_n;
            pm_q      <= pm_n;
            intr_q    <= intr_n;
            pc_q      <= pc_n;
            cause_q   <= cause_n;
            retired_q <= retired_n;
        end
    end

    assign cmt.cmt_stall_o           = (state != IDLE);
    assign cmt.global_trap_o         = trap_q;
    assign cmt.global_mret_o         = mret_q;
    assign cmt.global_sret_o         = sret_q;
    assign cmt.global_ret_o          = mret_q | sret_q;
    assign cmt.global_wfi_o          = (state == WFI);
    assign cmt.global_predict_miss_o = pm_q;
    assign cmt.csr_pc_o              = pc_q;
    assign cmt.csr_ecause_o          = cause_q;
    assign cmt.csr_intr_o            = intr_q;
    assign cmt.csr_retired_o         = retired_q;
    assign cmt.dbg_state             = state;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: single-cycle vector table plus flush, WFI and reset sequences.
module tb_trap_ctrl;
    localparam int CW = 2;
    localparam int PW = 40;
    localparam int EW = 4;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if #(.CMT_WIDTH(CW), .PC_WIDTH(PW), .EXCEPTION_CAUSE_WIDTH(EW), .RET_W(RW)) bus ();

    trap_ctrl #(
        .CMT_WIDTH(CW), .PC_WIDTH(PW), .EXCEPTION_CAUSE_WIDTH(EW), .FLUSH_CYCLES(2), .RET_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmt(bus)
    );

    typedef struct {
        logic [CW-1:0] valid, exp, mret, sret, wfi;
        logic [PW-1:0] pc0, pc1;
        logic [EW-1:0] c0, c1;
        logic          pm, irq;
        logic [RW-1:0] e_ret;
        logic          e_trap, e_mret, e_sret, e_pm, e_intr, e_stall;
        logic [PW-1:0] e_pc;
        logic [EW-1:0] e_cause;
    } vec_t;

    vec_t        vt[14];
    logic [RW-1:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CW-1:0] v, ex, mr, sr, wf, input logic [PW-1:0] p0, p1,
                         input logic [EW-1:0] c0, c1, input logic pm, irq);
        bus.rob_cmt_valid_i  = v;
        bus.rob_cmt_exp_i    = ex;
        bus.rob_cmt_mret_i   = mr;
        bus.rob_cmt_sret_i   = sr;
        bus.rob_cmt_wfi_i    = wf;
        bus.rob_cmt_pc_i     = {p1, p0};
        bus.rob_cmt_ecause_i = {c1, c0};
        bus.predict_miss_i   = pm;
        bus.interrupt_i      = irq;
    endtask

    task automatic clear();
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.cmt_stall_o && n < 20) begin
            step();
            n++;
        end
        chk({name, "_back_to_idle"}, 64'(bus.cmt_stall_o), 64'(0));
    endtask

    task automatic chk_zero(input string p);
        chk({p, "stall"}, 64'(bus.cmt_stall_o), 64'(0));
        chk({p, "trap"}, 64'(bus.global_trap_o), 64'(0));
        chk({p, "ret"}, 64'({bus.global_mret_o, bus.global_sret_o, bus.global_ret_o}), 64'(0));
        chk({p, "wfi"}, 64'(bus.global_wfi_o), 64'(0));
        chk({p, "pm"}, 64'(bus.global_predict_miss_o), 64'(0));
        chk({p, "csr"}, 64'({bus.csr_pc_o, bus.csr_ecause_o, bus.csr_intr_o}), 64'(0));
        chk({p, "retired"}, 64'(bus.csr_retired_o), 64'(0));
        chk({p, "state"}, 64'(bus.dbg_state), 64'(0));
    endtask

    task automatic chk_vec(input vec_t v, input int i);
        string p;
        p = $sformatf("v%0d_", i);
        chk({p, "retired"}, 64'(bus.csr_retired_o), 64'(v.e_ret));
        chk({p, "trap"}, 64'(bus.global_trap_o), 64'(v.e_trap));
        chk({p, "mret"}, 64'(bus.global_mret_o), 64'(v.e_mret));
        chk({p, "sret"}, 64'(bus.global_sret_o), 64'(v.e_sret));
        chk({p, "ret"}, 64'(bus.global_ret_o), 64'(v.e_mret | v.e_sret));
        chk({p, "pm"}, 64'(bus.global_predict_miss_o), 64'(v.e_pm));
        chk({p, "intr"}, 64'(bus.csr_intr_o), 64'(v.e_intr));
        chk({p, "stall"}, 64'(bus.cmt_stall_o), 64'(v.e_stall));
        chk({p, "state"}, 64'(bus.dbg_state), v.e_stall ? 64'(1) : 64'(0));
        chk({p, "wfi"}, 64'(bus.global_wfi_o), 64'(0));
        if (v.e_trap) begin
            chk({p, "pc"}, 64'(bus.csr_pc_o), 64'(v.e_pc));
            chk({p, "cause"}, 64'(bus.csr_ecause_o), 64'(v.e_cause));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{valid: 2'b11, pc0: 40'h100, pc1: 40'h104, e_ret: 2'd2, default: '0};
        vt[1]  = '{valid: 2'b01, pc0: 40'h120, e_ret: 2'd1, default: '0};
        vt[2]  = '{valid: 2'b11, exp: 2'b10, c1: 4'd5, pc0: 40'h200, pc1: 40'h204,
                   e_ret: 2'd1, e_trap: 1'b1, e_pc: 40'h204, e_cause: 4'd5, e_stall: 1'b1, default: '0};
        vt[3]  = '{valid: 2'b11, mret: 2'b01, exp: 2'b10, c1: 4'd6,
                   e_ret: 2'd1, e_mret: 1'b1, e_stall: 1'b1, default: '0};
        vt[4]  = '{valid: 2'b11, sret: 2'b10, e_ret: 2'd2, e_sret: 1'b1, e_stall: 1'b1, default: '0};
        vt[5]  = '{valid: 2'b11, exp: 2'b01, mret: 2'b01, c0: 4'd3, pc0: 40'h500,
                   e_trap: 1'b1, e_pc: 40'h500, e_cause: 4'd3, e_stall: 1'b1, default: '0};
        vt[6]  = '{valid: 2'b11, irq: 1'b1, exp: 2'b01, c0: 4'd7, pc0: 40'h400, pm: 1'b1,
                   e_trap: 1'b1, e_intr: 1'b1, e_pc: 40'h400, e_cause: 4'd0, e_stall: 1'b1, default: '0};
        vt[7]  = '{valid: 2'b11, pm: 1'b1, e_ret: 2'd2, e_pm: 1'b1, default: '0};
        vt[8]  = '{valid: 2'b00, irq: 1'b1, default: '0};
        vt[9]  = '{valid: 2'b00, default: '0};
        vt[10] = '{valid: 2'b11, mret: 2'b01, pm: 1'b1, e_ret: 2'd1, e_mret: 1'b1, e_stall: 1'b1, default: '0};
        vt[11] = '{valid: 2'b01, irq: 1'b1, pc0: 40'h600,
                   e_trap: 1'b1, e_intr: 1'b1, e_pc: 40'h600, e_stall: 1'b1, default: '0};
        vt[12] = '{valid: 2'b11, exp: 2'b01, sret: 2'b10, c0: 4'd2, pc0: 40'h700,
                   e_trap: 1'b1, e_pc: 40'h700, e_cause: 4'd2, e_stall: 1'b1, default: '0};
        vt[13] = '{valid: 2'b01, exp: 2'b10, c1: 4'd9, e_ret: 2'd1, default: '0};

        rst = 1'b1;
        clear();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_");
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].valid, vt[i].exp, vt[i].mret, vt[i].sret, vt[i].wfi, vt[i].pc0, vt[i].pc1,
                  vt[i].c0, vt[i].c1, vt[i].pm, vt[i].irq);
            step();
            chk_vec(vt[i], i);
            clear();
            wait_idle($sformatf("v%0d", i));
        end

        // Trap then two stalled cycles; commits offered during the flush must be ignored.
        drive(2'b11, 2'b01, '0, '0, '0, 40'h800, 40'h804, 4'd9, '0, 1'b0, 1'b0);
        step();
        chk("flush_trap", 64'(bus.global_trap_o), 64'(1));
        chk("flush_stall0", 64'(bus.cmt_stall_o), 64'(1));
        drive(2'b11, '0, '0, '0, '0, 40'h900, 40'h904, '0, '0, 1'b0, 1'b0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("flush_retired_c%0d", c), 64'(bus.csr_retired_o), 64'(exp_q.pop_front()));
            chk($sformatf("flush_stall_c%0d", c), 64'(bus.cmt_stall_o), (c == 1) ? 64'(1) : 64'(0));
        end
        clear();
        step();

        // Interrupt is ignored during FLUSH and held off in IDLE without a valid lane.
        drive(2'b01, 2'b01, '0, '0, '0, 40'ha00, '0, 4'd1, '0, 1'b0, 1'b0);
        step();
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("flush_irq_trap_c%0d", c), 64'(bus.global_trap_o), 64'(0));
        end
        clear();
        step();

        // WFI sleep, younger lane killed, then interrupt wake-up to pc+4.
        drive(2'b11, 2'b10, '0, '0, 2'b01, 40'h300, 40'h304, '0, 4'd4, 1'b0, 1'b0);
        step();
        chk("wfi_level", 64'(bus.global_wfi_o), 64'(1));
        chk("wfi_retired", 64'(bus.csr_retired_o), 64'(1));
        chk("wfi_trap", 64'(bus.global_trap_o), 64'(0));
        chk("wfi_state", 64'(bus.dbg_state), 64'(2));
        drive(2'b11, '0, '0, '0, '0, 40'h310, 40'h314, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("wfi_hold_c%0d", c), 64'({bus.global_wfi_o, bus.cmt_stall_o, bus.csr_retired_o}),
                64'({1'b1, 1'b1, 2'd0}));
        end
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        step();
        chk("wake_trap", 64'(bus.global_trap_o), 64'(1));
        chk("wake_intr", 64'(bus.csr_intr_o), 64'(1));
        chk("wake_pc", 64'(bus.csr_pc_o), 64'(40'h304));
        chk("wake_wfi", 64'(bus.global_wfi_o), 64'(0));
        chk("wake_state", 64'(bus.dbg_state), 64'(1));
        clear();
        wait_idle("wake");

        // pc+4 wraps at PC_WIDTH.
        drive(2'b01, '0, '0, '0, 2'b01, 40'hFF_FFFF_FFFE, '0, '0, '0, 1'b0, 1'b0);
        step();
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        step();
        chk("wrap_pc", 64'(bus.csr_pc_o), 64'(40'h2));
        clear();
        wait_idle("wrap");

        // Asynchronous reset in the middle of FLUSH.
        drive(2'b01, 2'b01, '0, '0, '0, 40'hb00, '0, 4'd3, '0, 1'b0, 1'b0);
        step();
        clear();
        chk("rstf_pre_trap", 64'(bus.global_trap_o), 64'(1));
        rst = 1'b1;
        #1;
        chk_zero("rstf_");
        step();
        rst = 1'b0;
        drive(2'b11, '0, '0, '0, '0, 40'hc00, 40'hc04, '0, '0, 1'b0, 1'b0);
        step();
        chk("rstf_after_retired", 64'(bus.csr_retired_o), 64'(2));
        chk("rstf_after_stall", 64'(bus.cmt_stall_o), 64'(0));

        // Asynchronous reset while sleeping in WFI.
        drive(2'b01, '0, '0, '0, 2'b01, 40'hd00, '0, '0, '0, 1'b0, 1'b0);
        step();
        clear();
        step();
        chk("rstw_pre_wfi", 64'(bus.global_wfi_o), 64'(1));
        rst = 1'b1;
        #1;
        chk_zero("rstw_");
        step();
        rst = 1'b0;
        drive(2'b11, '0, '0, '0, '0, 40'he00, 40'he04, '0, '0, 1'b0, 1'b0);
        step();
        chk("rstw_after_retired", 64'(bus.csr_retired_o), 64'(2));
        chk("rstw_after_stall", 64'(bus.cmt_stall_o), 64'(0));
        clear();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
